// File: rtl/a5_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : a5_sequencer
// Description : Frame sequencer for an external A5/1 LFSR trio: key/frame
//               load, majority warm-up and two handshaked keystream chunks.
// Revision    : 1.0 - initial release
// ============================================================================
module a5_sequencer #(
  parameter int KEYLEN      = 64,
  parameter int FRAMENUMLEN = 22,
  parameter int MIXLEN      = 100,
  parameter int CHUNKLEN    = 114
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KEYLEN-1:0]      key,
  input  logic [FRAMENUMLEN-1:0] frame,
  input  logic                   sync1,
  input  logic                   sync2,
  input  logic                   sync3,
  input  logic                   gamma,
  output logic                   lfsr_clear,
  output logic                   en1,
  output logic                   en2,
  output logic                   en3,
  output logic                   inject_bit,
  input  logic                   in_valid,
  input  logic                   in_bit,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic                   out_bit,
  output logic                   out_dir,
  output logic                   busy,
  output logic                   done
);

  localparam int c_KEY_IW   = $clog2(KEYLEN);
  localparam int c_FRAME_IW = $clog2(FRAMENUMLEN);

  localparam logic [6:0] c_KEY_LAST   = 7'(KEYLEN - 1);
  localparam logic [6:0] c_FRAME_LAST = 7'(FRAMENUMLEN - 1);
  localparam logic [6:0] c_MIX_LAST   = 7'(MIXLEN - 1);
  localparam logic [6:0] c_CHUNK_LAST = 7'(CHUNKLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_KEY      = 3'd2,
    S_FRAME    = 3'd3,
    S_MIX      = 3'd4,
    S_STREAM_A = 3'd5,
    S_STREAM_B = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [6:0]               r_idx;
  logic [6:0]               w_idx_next;
  logic                     w_adv;
  logic [KEYLEN-1:0]        r_key;
  logic [FRAMENUMLEN-1:0]   r_frame;
  logic                     w_maj;
  logic [2:0]               w_maj_en;
  logic [2:0]               w_en;
  logic                     w_hs;
  logic                     r_out_valid;
  logic                     r_out_bit;
  logic                     r_out_dir;

  assign w_maj    = (sync1 & sync2) | (sync1 & sync3) | (sync2 & sync3);
  assign w_maj_en = {sync1 == w_maj, sync2 == w_maj, sync3 == w_maj};
  assign {en1, en2, en3} = w_en;
  assign w_hs      = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign out_dir   = r_out_dir;

  always_comb begin
    w_state_next = r_state;
    w_adv        = 1'b0;
    w_en         = 3'b000;
    lfsr_clear   = 1'b0;
    inject_bit   = 1'b0;
    in_ready     = 1'b0;
    done         = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = S_CLEAR;
      end
      S_CLEAR: begin
        lfsr_clear   = 1'b1;
        w_state_next = S_KEY;
      end
      S_KEY: begin
        w_en       = 3'b111;
        inject_bit = r_key[r_idx[c_KEY_IW-1:0]];
        w_adv      = 1'b1;
        if (r_idx == c_KEY_LAST) w_state_next = S_FRAME;
      end
      S_FRAME: begin
        w_en       = 3'b111;
        inject_bit = r_frame[r_idx[c_FRAME_IW-1:0]];
        w_adv      = 1'b1;
        if (r_idx == c_FRAME_LAST) w_state_next = S_MIX;
      end
      S_MIX: begin
        w_en  = w_maj_en;
        w_adv = 1'b1;
        if (r_idx == c_MIX_LAST) w_state_next = S_STREAM_A;
      end
      S_STREAM_A, S_STREAM_B: begin
        in_ready = 1'b1;
        // Only accepted bits advance the keystream and the chunk count.
        if (in_valid) begin
          w_en  = w_maj_en;
          w_adv = 1'b1;
          if (r_idx == c_CHUNK_LAST)
            w_state_next = (r_state == S_STREAM_A) ? S_STREAM_B : S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_state_next != r_state) w_idx_next = 7'd0;
    else if (w_adv)              w_idx_next = r_idx + 7'd1;
    else                         w_idx_next = r_idx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 7'd0;
      r_key       <= '0;
      r_frame     <= '0;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_dir   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_out_valid <= w_hs;
      if (r_state == S_IDLE && start) begin
        r_key   <= key;
        r_frame <= frame;
      end
      // gamma is sampled here, before the LFSRs shift on this same edge.
      if (w_hs) begin
        r_out_bit <= in_bit ^ gamma;
        r_out_dir <= (r_state == S_STREAM_B);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_a5_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_a5_sequencer
// Description : Self-checking bench for a5_sequencer with A5/1 LFSR environment.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_a5_sequencer;

  localparam int KEYLEN      = 64;
  localparam int FRAMENUMLEN = 22;
  localparam int MIXLEN      = 100;
  localparam int CHUNKLEN    = 114;
  localparam int NBITS       = 2 * CHUNKLEN;
  localparam int MAXC        = 2000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [63:0] key   = '0;
  logic [21:0] frame = '0;
  logic        in_valid = 1'b0;
  logic        in_bit   = 1'b0;
  logic        sync1, sync2, sync3, gamma;
  logic        lfsr_clear, en1, en2, en3, inject_bit;
  logic        in_ready, out_valid, out_bit, out_dir, busy, done;

  logic        force_sync = 1'b0;
  logic [2:0]  fsync = 3'b000;
  logic [18:0] r1 = '0;
  logic [21:0] r2 = '0;
  logic [22:0] r3 = '0;

  int checks   = 0;
  int failures = 0;

  logic       lg_clear [MAXC];
  logic       lg_inj   [MAXC];
  logic       lg_rdy   [MAXC];
  logic       lg_busy  [MAXC];
  logic       lg_done  [MAXC];
  logic       lg_valid [MAXC];
  logic [2:0] lg_en    [MAXC];
  logic       q_in[$];
  logic       q_ob[$];
  logic       q_od[$];
  int         done_cyc;
  int         last_cyc;

  a5_sequencer #(
    .KEYLEN(KEYLEN), .FRAMENUMLEN(FRAMENUMLEN), .MIXLEN(MIXLEN), .CHUNKLEN(CHUNKLEN)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .key(key), .frame(frame),
    .sync1(sync1), .sync2(sync2), .sync3(sync3), .gamma(gamma),
    .lfsr_clear(lfsr_clear), .en1(en1), .en2(en2), .en3(en3), .inject_bit(inject_bit),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_bit(out_bit), .out_dir(out_dir),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Environment: the three A5/1 registers driven by the sequencer's controls.
  always @(posedge clock) begin
    if (lfsr_clear) begin
      r1 <= '0; r2 <= '0; r3 <= '0;
    end else begin
      if (en1) r1 <= {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18] ^ inject_bit};
      if (en2) r2 <= {r2[20:0], r2[20] ^ r2[21] ^ inject_bit};
      if (en3) r3 <= {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22] ^ inject_bit};
    end
  end

  assign sync1 = force_sync ? fsync[2] : r1[8];
  assign sync2 = force_sync ? fsync[1] : r2[10];
  assign sync3 = force_sync ? fsync[0] : r3[10];
  assign gamma = r1[18] ^ r2[21] ^ r3[22];

  // Keystream straight from the algorithm: ks[k] is the output after MIXLEN+k majority clocks.
  function automatic logic [NBITS-1:0] ref_ks(input logic [63:0] k, input logic [21:0] f);
    logic [18:0] a;
    logic [21:0] b;
    logic [22:0] c;
    logic [NBITS-1:0] ks;
    logic ib;
    int votes;
    logic maj;
    a = '0; b = '0; c = '0; ks = '0;
    for (int i = 0; i < KEYLEN + FRAMENUMLEN; i++) begin
      ib = (i < KEYLEN) ? k[i] : f[i - KEYLEN];
      a = {a[17:0], (^(a & 19'h72000)) ^ ib};
      b = {b[20:0], (^(b & 22'h300000)) ^ ib};
      c = {c[21:0], (^(c & 23'h700080)) ^ ib};
    end
    for (int s = 0; s < MIXLEN + NBITS; s++) begin
      if (s >= MIXLEN) ks[s - MIXLEN] = a[18] ^ b[21] ^ c[22];
      votes = int'(a[8]) + int'(b[10]) + int'(c[10]);
      maj = (votes >= 2);
      if (a[8]  == maj) a = {a[17:0], ^(a & 19'h72000)};
      if (b[10] == maj) b = {b[20:0], ^(b & 22'h300000)};
      if (c[10] == maj) c = {c[21:0], ^(c & 23'h700080)};
    end
    return ks;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // vmode: 0 = in_valid always 1, 1 = toggling, 2 = random 75 %.
  task automatic drive_frame(input logic [63:0] k, input logic [21:0] f, input int vmode,
                             input bit zero_in, input int restart_at);
    q_in.delete(); q_ob.delete(); q_od.delete();
    done_cyc = -1;
    last_cyc = 0;
    @(negedge clock);
    key = k; frame = f; start = 1'b1; in_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c < MAXC; c++) begin
      start = (c == restart_at);
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (c % 2 == 0);
        default: in_valid = ($urandom_range(3) != 0);
      endcase
      in_bit = zero_in ? 1'b0 : 1'($urandom_range(1));
      #1;
      lg_clear[c] = lfsr_clear; lg_inj[c] = inject_bit; lg_rdy[c] = in_ready;
      lg_busy[c] = busy; lg_done[c] = done; lg_valid[c] = in_valid;
      lg_en[c] = {en1, en2, en3};
      if (out_valid) begin
        q_ob.push_back(out_bit);
        q_od.push_back(out_dir);
      end
      if (in_valid && in_ready) q_in.push_back(in_bit);
      last_cyc = c;
      if (done_cyc >= 0) break;
      if (done) done_cyc = c;
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, done, out_valid, out_bit, out_dir, in_ready, en1, en2, en3, inject_bit, lfsr_clear} !== 11'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0",
               {busy, done, out_valid, out_bit, out_dir, in_ready, en1, en2, en3, inject_bit, lfsr_clear});
    end
    @(negedge clock);
    start = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_autostart busy=%b exp=0", busy);
    end
  endtask

  task automatic test_phase_timing();
    logic [63:0] k;
    logic [21:0] f;
    logic [4:0]  e;
    logic        ei;
    k = {$urandom, $urandom};
    f = 22'($urandom);
    drive_frame(k, f, 0, 0, 0);
    checks++;
    if (done_cyc !== 416) begin
      failures++;
      $display("FAIL phase_done_cycle got=%0d exp=416", done_cyc);
    end
    for (int c = 1; c <= last_cyc; c++) begin
      if (c >= 2 && c <= 65)       ei = k[c - 2];
      else if (c >= 66 && c <= 87) ei = f[c - 66];
      else                         ei = 1'b0;
      e = {c == 1, c <= 416, c == 416, (c >= 188 && c <= 415), ei};
      checks++;
      if ({lg_clear[c], lg_busy[c], lg_done[c], lg_rdy[c], lg_inj[c]} !== e) begin
        failures++;
        $display("FAIL phase_ctrl cyc=%0d got=%b exp=%b (clear,busy,done,ready,inject)",
                 c, {lg_clear[c], lg_busy[c], lg_done[c], lg_rdy[c], lg_inj[c]}, e);
      end
      checks++;
      if (c >= 2 && c <= 87) begin
        if (lg_en[c] !== 3'b111) begin
          failures++;
          $display("FAIL phase_load_en cyc=%0d got=%b exp=111", c, lg_en[c]);
        end
      end else if (c == 1 || c >= 416) begin
        if (lg_en[c] !== 3'b000) begin
          failures++;
          $display("FAIL phase_idle_en cyc=%0d got=%b exp=000", c, lg_en[c]);
        end
      end else if ($countones(lg_en[c]) < 2) begin
        failures++;
        $display("FAIL phase_maj_en cyc=%0d got=%b exp=at least two set", c, lg_en[c]);
      end
    end
  endtask

  task automatic test_key_order();
    drive_frame(64'h1, 22'h0, 0, 0, 0);
    for (int c = 2; c <= 87; c++) begin
      checks++;
      if (lg_inj[c] !== (c == 2)) begin
        failures++;
        $display("FAIL key_order cyc=%0d inject=%b exp=%b", c, lg_inj[c], (c == 2));
      end
    end
  endtask

  task automatic test_majority();
    int v;
    logic m;
    logic [2:0] e;
    @(negedge clock);
    key = {$urandom, $urandom}; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (99) tick();
    force_sync = 1'b1;
    for (int s = 0; s < 8; s++) begin
      @(negedge clock);
      fsync = 3'(s);
      #1;
      v = int'(fsync[2]) + int'(fsync[1]) + int'(fsync[0]);
      m = (v >= 2);
      e = {fsync[2] == m, fsync[1] == m, fsync[0] == m};
      checks++;
      if ({en1, en2, en3} !== e) begin
        failures++;
        $display("FAIL majority sync=%b en=%b exp=%b", fsync, {en1, en2, en3}, e);
      end
    end
    force_sync = 1'b0;
    #1 reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL majority_abort busy=%b exp=0", busy);
    end
  endtask

  task automatic test_stall();
    logic [63:0] k;
    logic [21:0] f;
    logic [NBITS-1:0] ks, act, exp_v, act_d, exp_d;
    int bad_en;
    k = {$urandom, $urandom};
    f = 22'($urandom);
    ks = ref_ks(k, f);
    drive_frame(k, f, 1, 0, 0);
    bad_en = 0;
    for (int c = 188; c <= last_cyc; c++)
      if (lg_rdy[c] && !lg_valid[c] && lg_en[c] !== 3'b000) bad_en++;
    checks++;
    if (bad_en != 0) begin
      failures++;
      $display("FAIL stall_en_on_idle cycles_with_enable=%0d exp=0", bad_en);
    end
    checks++;
    if (done_cyc !== 643) begin
      failures++;
      $display("FAIL stall_done_cycle got=%0d exp=643", done_cyc);
    end
    checks++;
    if (q_ob.size() != NBITS) begin
      failures++;
      $display("FAIL stall_pulses got=%0d exp=%0d", q_ob.size(), NBITS);
    end
    act = '0; exp_v = '0; act_d = '0; exp_d = '0;
    for (int j = 0; j < NBITS; j++) begin
      if (j < q_ob.size()) begin act[j] = q_ob[j]; act_d[j] = q_od[j]; end
      if (j < q_in.size()) exp_v[j] = q_in[j] ^ ks[j];
      exp_d[j] = (j >= CHUNKLEN);
    end
    checks++;
    if (act_d !== exp_d) begin
      failures++;
      $display("FAIL stall_dir got=%h exp=%h", act_d, exp_d);
    end
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL stall_data got=%h exp=%h", act, exp_v);
    end
  endtask

  task automatic test_random();
    logic [63:0] k;
    logic [21:0] f;
    logic [NBITS-1:0] ks, act, exp_v, act_d, exp_d;
    for (int t = 0; t < 3; t++) begin
      k = {$urandom, $urandom};
      f = 22'($urandom);
      ks = ref_ks(k, f);
      drive_frame(k, f, 2, 0, 0);
      checks++;
      if (q_ob.size() != NBITS || q_in.size() != NBITS || done_cyc < 0) begin
        failures++;
        $display("FAIL random_count t=%0d out=%0d in=%0d done_cyc=%0d", t, q_ob.size(), q_in.size(), done_cyc);
      end
      act = '0; exp_v = '0; act_d = '0; exp_d = '0;
      for (int j = 0; j < NBITS; j++) begin
        if (j < q_ob.size()) begin act[j] = q_ob[j]; act_d[j] = q_od[j]; end
        if (j < q_in.size()) exp_v[j] = q_in[j] ^ ks[j];
        exp_d[j] = (j >= CHUNKLEN);
      end
      checks++;
      if (act !== exp_v || act_d !== exp_d) begin
        failures++;
        $display("FAIL random_data t=%0d got=%h exp=%h dir_got=%h", t, act, exp_v, act_d);
      end
    end
  endtask

  task automatic test_full_reference(input int restart_at, input string tag);
    logic [NBITS-1:0] ks, act;
    ks = ref_ks(64'h0123456789ABCDEF, 22'h134);
    drive_frame(64'h0123456789ABCDEF, 22'h134, 0, 1, restart_at);
    checks++;
    if (done_cyc !== 416) begin
      failures++;
      $display("FAIL %s_done_cycle got=%0d exp=416", tag, done_cyc);
    end
    act = '0;
    for (int j = 0; j < NBITS && j < q_ob.size(); j++) act[j] = q_ob[j];
    checks++;
    if (act !== ks) begin
      failures++;
      $display("FAIL %s_keystream got=%h exp=%h", tag, act, ks);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    key = {$urandom, $urandom}; frame = 22'($urandom); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (149) tick();
    checks++;
    if (busy !== 1'b1 || $countones({en1, en2, en3}) < 2) begin
      failures++;
      $display("FAIL reset_mid_pre busy=%b en=%b exp busy=1 en>=2", busy, {en1, en2, en3});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, out_valid, out_bit, out_dir, in_ready, en1, en2, en3, inject_bit, lfsr_clear} !== 11'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%b exp=0",
               {busy, done, out_valid, out_bit, out_dir, in_ready, en1, en2, en3, inject_bit, lfsr_clear});
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_idle busy=%b exp=0", busy);
    end
    test_full_reference(120, "restart");
  endtask

  initial begin
    test_reset();
    test_phase_timing();
    test_key_order();
    test_majority();
    test_stall();
    test_random();
    test_full_reference(0, "fullref");
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
